// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns a stream of instruction requests (ADD, SUB, OR, AND, ADDI, ORI, ANDI,
//   LW, SW, BEQ) into RV32I machine words. Each accepted request is written to
//   instruction memory one cycle later, at consecutive word addresses starting
//   at BASE_ADDR. A load ends on in_last or when DEPTH words have been written.
//
//   Build option: define INSTR_ENCODER_RANGE_CHECK_EN to reject immediates that
//   do not fit their encoding (a NOP is written and err is set). When it is
//   undefined, immediates are silently truncated to the encodable bits.
//
//   Parameters
//     BASE_ADDR  byte address of the first word written
//     DEPTH      maximum words per program (1..65535)
//   Ports
//     clk, rst_n            clock, async active-low reset
//     start                 pulse in IDLE begins a program load
//     in_valid / in_ready   request handshake
//     in_kind               instruction selector (10..15 invalid)
//     in_rd/in_rs1/in_rs2   register indices
//     in_imm                signed immediate (byte offset for BEQ)
//     in_last               final request of the program
//     mem_we/addr/wdata     instruction-memory write port
//     done                  one-cycle pulse after the last write
//     full                  sticky, DEPTH words written
//     err                   sticky, an encoding error occurred
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        full,
    output logic        err
);

    // Count must be able to hold DEPTH itself (up to 65535).
    localparam int unsigned CNT_W  = 17;
    localparam int unsigned WORD_W = 32;

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_OR   = 4'd2;
    localparam logic [3:0] K_AND  = 4'd3;
    localparam logic [3:0] K_ADDI = 4'd4;
    localparam logic [3:0] K_ORI  = 4'd5;
    localparam logic [3:0] K_ANDI = 4'd6;
    localparam logic [3:0] K_LW   = 4'd7;
    localparam logic [3:0] K_SW   = 4'd8;
    localparam logic [3:0] K_BEQ  = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [WORD_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               done_q, done_d;
    logic               full_q, full_d;
    logic               err_q, err_d;

    logic [WORD_W-1:0]  enc_word_c;
    logic               enc_err_c;
    logic               imm12_ok_c;
    logic               imm13_ok_c;
    logic               is_is_type_c;
    logic               is_b_type_c;
    logic               accept_c;
    logic [CNT_W-1:0]   count_inc_c;

    // Immediate legality: 12-bit signed for I/S, 13-bit signed even for BEQ.
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    assign imm12_ok_c = (in_imm[31:11] == {21{in_imm[11]}});
    assign imm13_ok_c = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
`else
    logic unused_imm_c;
    assign imm12_ok_c   = 1'b1;
    assign imm13_ok_c   = 1'b1;
    assign unused_imm_c = ^{in_imm[31:13], in_imm[0]};
`endif

    assign is_is_type_c = (in_kind == K_ADDI) || (in_kind == K_ORI)  ||
                          (in_kind == K_ANDI) || (in_kind == K_LW)   ||
                          (in_kind == K_SW);
    assign is_b_type_c  = (in_kind == K_BEQ);

    // Instruction word formation; illegal kind or immediate yields a NOP.
    always_comb begin
        enc_word_c = NOP_WORD;
        enc_err_c  = 1'b0;
        unique case (in_kind)
            K_ADD:  enc_word_c = {F7_BASE, in_rs2, in_rs1, F3_ADD, in_rd, OP_R};
            K_SUB:  enc_word_c = {F7_SUB,  in_rs2, in_rs1, F3_ADD, in_rd, OP_R};
            K_OR:   enc_word_c = {F7_BASE, in_rs2, in_rs1, F3_OR,  in_rd, OP_R};
            K_AND:  enc_word_c = {F7_BASE, in_rs2, in_rs1, F3_AND, in_rd, OP_R};
            K_ADDI: enc_word_c = {in_imm[11:0], in_rs1, F3_ADD, in_rd, OP_IMM};
            K_ORI:  enc_word_c = {in_imm[11:0], in_rs1, F3_OR,  in_rd, OP_IMM};
            K_ANDI: enc_word_c = {in_imm[11:0], in_rs1, F3_AND, in_rd, OP_IMM};
            K_LW:   enc_word_c = {in_imm[11:0], in_rs1, F3_W,   in_rd, OP_LOAD};
            K_SW:   enc_word_c = {in_imm[11:5], in_rs2, in_rs1, F3_W,
                                  in_imm[4:0], OP_STORE};
            K_BEQ:  enc_word_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BEQ,
                                  in_imm[4:1], in_imm[11], OP_BRANCH};
            default: begin
                enc_word_c = NOP_WORD;
                enc_err_c  = 1'b1;
            end
        endcase
        if ((is_is_type_c && !imm12_ok_c) || (is_b_type_c && !imm13_ok_c)) begin
            enc_word_c = NOP_WORD;
            enc_err_c  = 1'b1;
        end
    end

    assign accept_c    = in_valid && in_ready_q;
    assign count_inc_c = count_q + CNT_W'(1);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic. The write is registered at the acceptance edge, so the
    // FSM enters DONE in the write cycle and done appears one cycle later.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        full_d      = full_q;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_ADDR + (WORD_W'(count_q) << 2);
                    mem_wdata_d = enc_word_c;
                    err_d       = err_q | enc_err_c;
                    count_d     = count_inc_c;
                    if (count_inc_c == DEPTH_C) begin
                        full_d = 1'b1;
                    end
                    // in_last and reaching DEPTH together still give one done.
                    if (in_last || (count_inc_c == DEPTH_C)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_RUN) && (count_d < DEPTH_C);
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign full      = full_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder. A table of single-instruction programs
//   is replayed and checked word by word, followed by hand-written sequences
//   for back-to-back bursts, the DEPTH limit with address wrap, and reset in
//   the middle of a load.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready0, mem_we0, done0, full0, err0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic        in_ready1, mem_we1, done1, full1, err1;
    logic [31:0] mem_addr1, mem_wdata1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .done(done0), .full(full0), .err(err0)
    );

    // Same stimulus, base near the top of the address space.
    instr_encoder #(.BASE_ADDR(32'hFFFF_FFF8), .DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .done(done1), .full(full1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [3:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        in_valid = 1'b1;
        in_kind  = k;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_last  = last;
    endtask

    task automatic idle_req();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_one(input vec_t v);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({v.name, " in_ready"}, 32'(in_ready0), 32'd1);
        set_req(v.kind, v.rd, v.rs1, v.rs2, v.imm, 1'b1);
        tick();
        idle_req();
        chk({v.name, " mem_we"}, 32'(mem_we0), 32'd1);
        chk({v.name, " addr"}, mem_addr0, 32'h0);
        chk({v.name, " word"}, mem_wdata0, v.word);
        chk({v.name, " err"}, 32'(err0), 32'(v.err));
        tick();
        chk({v.name, " done"}, 32'(done0), 32'd1);
        chk({v.name, " we_off"}, 32'(mem_we0), 32'd0);
        chk({v.name, " err_held"}, 32'(err0), 32'(v.err));
        tick();
        chk({v.name, " done_off"}, 32'(done0), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"add",   4'd0,  5'd1,  5'd2,  5'd3,  32'd0,         32'h003100B3, 1'b0};
        vecs[1]  = '{"sub",   4'd1,  5'd3,  5'd1,  5'd2,  32'd0,         32'h402081B3, 1'b0};
        vecs[2]  = '{"or",    4'd2,  5'd5,  5'd6,  5'd7,  32'd0,         32'h007362B3, 1'b0};
        vecs[3]  = '{"and",   4'd3,  5'd10, 5'd11, 5'd12, 32'd0,         32'h00C5F533, 1'b0};
        vecs[4]  = '{"addi",  4'd4,  5'd1,  5'd2,  5'd31, 32'hFFFF_FFFF, 32'hFFF10093, 1'b0};
        vecs[5]  = '{"ori",   4'd5,  5'd4,  5'd5,  5'd31, 32'd2047,      32'h7FF2E213, 1'b0};
        vecs[6]  = '{"andi",  4'd6,  5'd31, 5'd31, 5'd9,  32'hFFFF_F800, 32'h800FFF93, 1'b0};
        vecs[7]  = '{"lw",    4'd7,  5'd8,  5'd2,  5'd17, 32'hFFFF_FFFC, 32'hFFC12403, 1'b0};
        vecs[8]  = '{"sw",    4'd8,  5'd0,  5'd6,  5'd5,  32'd8,         32'h00532423, 1'b0};
        vecs[9]  = '{"beq_n", 4'd9,  5'd0,  5'd1,  5'd2,  32'hFFFF_FFFC, 32'hFE208EE3, 1'b0};
        vecs[10] = '{"inv12", 4'd12, 5'd1,  5'd2,  5'd3,  32'd5,         32'h00000013, 1'b1};
        vecs[11] = '{"beq_p", 4'd9,  5'd0,  5'd3,  5'd4,  32'd16,        32'h00418863, 1'b0};
        vecs[12] = '{"inv15", 4'd15, 5'd7,  5'd7,  5'd7,  32'd0,         32'h00000013, 1'b1};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        vecs[13] = '{"addi4k", 4'd4, 5'd1,  5'd2,  5'd0,  32'd4096,      32'h00000013, 1'b1};
`else
        vecs[13] = '{"addi4k", 4'd4, 5'd1,  5'd2,  5'd0,  32'd4096,      32'h00010093, 1'b0};
`endif

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_kind  = '0;
        in_rd    = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        in_imm   = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(in_ready0), 32'd0);
        chk("rst mem_we",   32'(mem_we0),   32'd0);
        chk("rst addr",     mem_addr0,      32'd0);
        chk("rst wdata",    mem_wdata0,     32'd0);
        chk("rst done",     32'(done0),     32'd0);
        chk("rst full",     32'(full0),     32'd0);
        chk("rst err",      32'(err0),      32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle in_ready", 32'(in_ready0), 32'd0);

        for (int i = 0; i < 14; i++) run_one(vecs[i]);

        // Back-to-back burst: one write per cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        set_req(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        tick();
        set_req(4'd8, 5'd0, 5'd6, 5'd5, 32'd8, 1'b0);
        chk("burst0 we",   32'(mem_we0), 32'd1);
        chk("burst0 addr", mem_addr0, 32'h0);
        chk("burst0 word", mem_wdata0, 32'h402081B3);
        tick();
        set_req(4'd9, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1);
        chk("burst1 we",   32'(mem_we0), 32'd1);
        chk("burst1 addr", mem_addr0, 32'h4);
        chk("burst1 word", mem_wdata0, 32'h00532423);
        tick();
        idle_req();
        chk("burst2 we",   32'(mem_we0), 32'd1);
        chk("burst2 addr", mem_addr0, 32'h8);
        chk("burst2 word", mem_wdata0, 32'hFE208EE3);
        chk("burst2 full", 32'(full0), 32'd0);
        tick();
        chk("burst done",  32'(done0), 32'd1);
        tick();

        // DEPTH limit with valid held and no in_last; dut1 wraps its address.
        start = 1'b1;
        tick();
        start = 1'b0;
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("full%0d we", i),    32'(mem_we0), 32'd1);
            chk($sformatf("full%0d addr", i),  mem_addr0, 32'(4 * i));
            chk($sformatf("full%0d waddr", i), mem_addr1, 32'hFFFF_FFF8 + 32'(4 * i));
            chk($sformatf("full%0d word", i),  mem_wdata0, 32'h003100B3);
        end
        chk("full flag",     32'(full0),     32'd1);
        chk("full flag w",   32'(full1),     32'd1);
        chk("full in_ready", 32'(in_ready0), 32'd0);
        tick();
        chk("full done",     32'(done0),     32'd1);
        chk("full no_we",    32'(mem_we0),   32'd0);
        tick();
        chk("full done_off", 32'(done0),     32'd0);
        chk("full no_we2",   32'(mem_we0),   32'd0);
        chk("full rdy_off",  32'(in_ready0), 32'd0);
        chk("full sticky",   32'(full0),     32'd1);
        idle_req();
        tick();

        // Reset while a request is being accepted: its write must not appear.
        start = 1'b1;
        tick();
        start = 1'b0;
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        idle_req();
        chk("rstmid we",    32'(mem_we0),   32'd0);
        chk("rstmid addr",  mem_addr0,      32'd0);
        chk("rstmid wdata", mem_wdata0,     32'd0);
        chk("rstmid ready", 32'(in_ready0), 32'd0);
        chk("rstmid full",  32'(full0),     32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rstmid idle_we",  32'(mem_we0),   32'd0);
        chk("rstmid idle_rdy", 32'(in_ready0), 32'd0);
        chk("rstmid idle_done", 32'(done0),    32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
